cache_fill_ctrl: RTL
====================

Name: cache_fill_ctrl

Overview:
- Fill engine for the byte-wide, direct-indexed cache lines; it is the writer side of the line fill port.
- On a miss it picks a victim line round-robin and fetches BLOCK_SIZE bytes from backing memory over a req/ack bus.
- It streams the bytes into the victim through fill_line_en/fill_en/fill_off/fill_data, then commits the tag with fill_tag_en on the final byte.

Parameters:
- ADDR_WIDTH, 16, CPU byte address width.
- BLOCK_SIZE, 8, bytes per line; power of two, at least 2. Localparam OFFSET_WIDTH = $clog2(BLOCK_SIZE).
- NUM_LINES, 4, number of cache lines; sets the width of fill_line_en.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- miss_req  in  1  miss pending; sampled only in IDLE
- miss_addr  in  ADDR_WIDTH  byte address that missed; sampled with miss_req
- busy  out  1  fill in progress (FETCH or DONE)
- fill_done  out  1  one-cycle pulse when the line is complete and the tag is committed
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_ack  in  1  memory accepts the request; mem_rdata is valid this cycle
- mem_rdata  in  8  memory read data
- fill_line_en  out  NUM_LINES  one-hot victim select
- fill_tag_en  out  1  commit tag and set valid in the selected line
- fill_en  out  1  write fill_data at fill_off in the selected line
- fill_off  out  OFFSET_WIDTH  byte offset within the line
- fill_data  out  8  fill byte
- crit_valid  out  1  critical byte forwarded (optional feature)
- crit_data  out  8  critical byte value (optional feature)

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer at line 0, beat counter 0.
- States and transitions:
  - IDLE: if miss_req=1, latch base = miss_addr with the offset bits cleared, set start offset = 0, latch victim = pointer, go to FETCH. miss_req is not acknowledged separately; the requester holds it until fill_done and drops it that same cycle. If miss_req is still 1 in the IDLE cycle after DONE, a new fill starts.
  - FETCH:
    - mem_req=1, mem_addr = base | cur_off, with cur_off = start + beat (mod BLOCK_SIZE).
    - mem_req and mem_addr stay stable until mem_ack.
    - Back-to-back beats allowed: mem_req stays high and the address advances in the cycle after an ack.
    - On mem_ack: register fill_data <= mem_rdata, fill_off <= cur_off, fill_en <= 1 for exactly one cycle, beat++.
    - If beat == BLOCK_SIZE-1 at ack, also set fill_tag_en <= 1 and go to DONE.
  - DONE: the registered fill_en/fill_tag_en for the last byte are visible this cycle, fill_done=1, pointer advances (NUM_LINES-1 wraps to 0), next state IDLE.
- busy=1 in FETCH and DONE.
- fill_line_en = one-hot(victim) in FETCH and DONE, plus the one cycle after the last FETCH ack. It is 0 in IDLE, so it is never active without a pending fill.
- fill_tag_en is asserted only with the final byte, so a partially filled line is never valid.
- No fill_en without a prior mem_ack; exactly BLOCK_SIZE fill_en pulses per fill.
- Latency with zero wait states: accept at T0; acks T1..T(B); fill_en T2..T(B+1); fill_done T(B+1).
- Reset mid-fill: immediate return to IDLE, all outputs 0. The victim line never receives fill_tag_en and stays invalid. The pointer resets to 0.
- mem_ack outside FETCH is ignored.

Optional Feature:
- Macro: CACHE_FILL_CRITICAL_FIRST_EN.
- Defined:
  - Start offset = miss_addr offset bits, and the burst wraps within the line.
  - crit_valid pulses with the first fill_en, and crit_data = the first fill byte, so the CPU can restart early.
  - fill_tag_en still accompanies only the last beat.
- Undefined: start offset is always 0, crit_valid and crit_data are tied to 0.

Test Plan:
- Zero-wait fill, miss_addr=0x1234, mem_rdata=low address byte:
  - mem_addr 0x1230..0x1237 on consecutive cycles.
  - fill_en x8 with fill_off 0..7 and data 0x30..0x37.
  - fill_tag_en only with off 7; fill_line_en=4'b0001; fill_done 9 cycles after accept.
- Wait states: mem_ack every 4th cycle -> mem_req held high, mem_addr stable during waits, no fill_en between acks, fill_done after 8 acks plus 1 cycle.
- Round-robin: five sequential misses -> fill_line_en 0001, 0010, 0100, 1000, 0001.
- Reset after 3 acks -> all outputs 0 the same cycle, no fill_tag_en ever issued, the next miss fills line 0001.
- miss_req held one cycle past fill_done -> second fill starts from IDLE with the next victim; mem_ack pulsed while IDLE -> no fill_en.
- With CACHE_FILL_CRITICAL_FIRST_EN, miss_addr=0x1235:
  - mem_addr order 0x1235, 0x1236, 0x1237, 0x1230 .. 0x1234.
  - crit_valid with crit_data=0x35 on the first fill_en.
  - fill_tag_en with fill_off=4.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: line fill engine for a byte-wide, direct-indexed cache.
// On a miss it picks a victim line round-robin. It then reads BLOCK_SIZE bytes
// from backing memory over a req/ack bus and streams them into the victim line.
// The tag is committed together with the final byte.
//
// Optional feature: define CACHE_FILL_CRITICAL_FIRST_EN for critical-word-first
// bursts. The burst starts at the missing byte, wraps within the line, and the
// first byte is also forwarded on crit_valid/crit_data.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   miss_req/miss_addr miss request and byte address (sampled in IDLE)
//   busy, fill_done    fill in progress; one-cycle completion pulse
//   mem_req/mem_addr   memory read request and address, held until mem_ack
//   mem_ack/mem_rdata  memory accept and read data (same cycle)
//   fill_line_en       one-hot victim line select
//   fill_tag_en        commit tag and set valid (final byte only)
//   fill_en/off/data   byte write into the selected line
//   crit_valid/data    early forward of the first fetched byte (optional)
module cache_fill_ctrl #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned BLOCK_SIZE = 8,
   parameter int unsigned NUM_LINES  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          miss_req,
   input  logic [ADDR_WIDTH-1:0]         miss_addr,
   output logic                          busy,
   output logic                          fill_done,
   output logic                          mem_req,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic                          mem_ack,
   input  logic [7:0]                    mem_rdata,
   output logic [NUM_LINES-1:0]          fill_line_en,
   output logic                          fill_tag_en,
   output logic                          fill_en,
   output logic [$clog2(BLOCK_SIZE)-1:0] fill_off,
   output logic [7:0]                    fill_data,
   output logic                          crit_valid,
   output logic [7:0]                    crit_data
);

   localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE);
   localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
   localparam int unsigned LINE_WIDTH   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
   localparam logic CRIT_EN = 1'b1;
`else
   localparam logic CRIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [LINE_WIDTH-1:0]   ptr_q, ptr_d;
   logic [LINE_WIDTH-1:0]   victim_q, victim_d;
   logic [TAG_WIDTH-1:0]    tag_q, tag_d;
   logic [OFFSET_WIDTH-1:0] start_q, start_d;
   logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
   logic [OFFSET_WIDTH-1:0] cur_off;

   logic                    busy_d, fill_done_d, mem_req_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_d;
   logic [NUM_LINES-1:0]    fill_line_en_d;
   logic                    fill_tag_en_d, fill_en_d;
   logic [OFFSET_WIDTH-1:0] fill_off_d;
   logic [7:0]              fill_data_d;

   // Offset of the byte currently requested; wraps within the line.
   assign cur_off = OFFSET_WIDTH'(start_q + beat_q);

   // Next-state and next-output logic; outputs are registered from these.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      victim_d      = victim_q;
      tag_d         = tag_q;
      start_d       = start_q;
      beat_d        = beat_q;
      fill_en_d     = 1'b0;
      fill_tag_en_d = 1'b0;
      fill_off_d    = fill_off;
      fill_data_d   = fill_data;

      case (state_q)
         S_IDLE: begin
            if (miss_req) begin
               tag_d    = miss_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
               // Start offset is the missing byte only in critical-first mode.
               start_d  = miss_addr[OFFSET_WIDTH-1:0] & {OFFSET_WIDTH{CRIT_EN}};
               beat_d   = '0;
               victim_d = ptr_q;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: begin
            if (mem_ack) begin
               fill_en_d   = 1'b1;
               fill_data_d = mem_rdata;
               fill_off_d  = cur_off;
               beat_d      = beat_q + OFFSET_WIDTH'(1);
               if (beat_q == OFFSET_WIDTH'(BLOCK_SIZE - 1)) begin
                  fill_tag_en_d = 1'b1;
                  state_d       = S_DONE;
               end
            end
         end
         S_DONE: begin
            ptr_d   = (ptr_q == LINE_WIDTH'(NUM_LINES - 1)) ? '0 : ptr_q + LINE_WIDTH'(1);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status and bus outputs follow the state being entered.
      busy_d         = (state_d != S_IDLE);
      fill_done_d    = (state_d == S_DONE);
      mem_req_d      = (state_d == S_FETCH);
      mem_addr_d     = mem_req_d ? {tag_d, OFFSET_WIDTH'(start_d + beat_d)} : '0;
      fill_line_en_d = busy_d ? (NUM_LINES'(1) << victim_d) : '0;
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         victim_q     <= '0;
         tag_q        <= '0;
         start_q      <= '0;
         beat_q       <= '0;
         busy         <= 1'b0;
         fill_done    <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         fill_line_en <= '0;
         fill_tag_en  <= 1'b0;
         fill_en      <= 1'b0;
         fill_off     <= '0;
         fill_data    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         victim_q     <= victim_d;
         tag_q        <= tag_d;
         start_q      <= start_d;
         beat_q       <= beat_d;
         busy         <= busy_d;
         fill_done    <= fill_done_d;
         mem_req      <= mem_req_d;
         mem_addr     <= mem_addr_d;
         fill_line_en <= fill_line_en_d;
         fill_tag_en  <= fill_tag_en_d;
         fill_en      <= fill_en_d;
         fill_off     <= fill_off_d;
         fill_data    <= fill_data_d;
      end
   end

`ifdef CACHE_FILL_CRITICAL_FIRST_EN
   logic       crit_valid_d;
   logic [7:0] crit_data_d;

   // The first ack of a burst carries the byte the CPU missed on.
   always_comb begin
      crit_valid_d = 1'b0;
      crit_data_d  = crit_data;
      if (state_q == S_FETCH && mem_ack && beat_q == '0) begin
         crit_valid_d = 1'b1;
         crit_data_d  = mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crit_valid <= 1'b0;
         crit_data  <= '0;
      end else begin
         crit_valid <= crit_valid_d;
         crit_data  <= crit_data_d;
      end
   end
`else
   assign crit_valid = 1'b0;
   assign crit_data  = 8'h00;
`endif

endmodule
